vend_ctrl: RTL and testbench
============================

Name: vend_ctrl

Overview:
- Coin-accumulating vending controller FSM that sits directly above the gate-level cell library; its synthesized netlist is mapped onto VNAND/VNOR/VNOT/PDFF cells.
- Accepts single-cycle coin pulses and accumulates credit in nickel units.
- Issues one dispense pulse when credit reaches the price.
- Returns remaining credit as a train of one-nickel change pulses. Cancel returns all credit.

Parameters:
- PRICE_N, 4, item price in nickels (4 = 20 cents); must be 1..MAX_CREDIT_N.
- CREDIT_W, 4, width of the credit register and the credit output.
- MAX_CREDIT_N, 15, highest credit value accepted; must be <= 2^CREDIT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- clrbar  in  1  synchronous active-low reset.
- nickel  in  1  one-cycle pulse, coin worth 1 unit.
- dime  in  1  one-cycle pulse, coin worth 2 units.
- quarter  in  1  one-cycle pulse, coin worth 5 units.
- cancel  in  1  one-cycle pulse, request refund of all credit.
- dispense  out  1  one-cycle pulse, release item.
- change  out  1  one-cycle pulse, return one nickel.
- coin_return  out  1  one-cycle pulse, the coin sampled at the previous edge was rejected.
- credit  out  CREDIT_W  current credit in nickels.
- busy  out  1  high in any state other than ACCEPT.

Behaviour:
- All outputs are registered. Every input is sampled at the rising edge of clk.
- Reset: clrbar=0 at an edge forces state=ACCEPT and clears credit, dispense, change, coin_return and busy to 0. Reset overrides everything, including mid-vend or mid-change; any unreturned credit is discarded.
- States: ACCEPT, VEND, CHANGE. busy = (state != ACCEPT), registered with the state.
- Default each edge: dispense, change and coin_return go to 0 unless set by a rule below.

ACCEPT:
- Coin valid: exactly one of nickel, dime, quarter is high.
- More than one coin input high at the same edge: reject all of them. coin_return=1 and credit is unchanged.
- Valid coin where credit+value > MAX_CREDIT_N: reject it. coin_return=1 and credit is unchanged.
- Valid coin otherwise: credit <= credit+value, computed CREDIT_W+1 wide with no wrap.
  - If the new credit >= PRICE_N, state <= VEND at the same edge.
- cancel=1 with credit>0: state <= CHANGE. Any coin at the same edge is rejected (coin_return=1); cancel has priority.
- cancel=1 with credit=0: cancel is ignored. A coin at the same edge is processed normally.

VEND (always exactly one cycle):
- dispense <= 1 and credit <= credit-PRICE_N.
- state <= CHANGE if the remainder is > 0, else ACCEPT.

CHANGE:
- Each edge: change <= 1 and credit <= credit-1.
- When credit==1 at the edge, state <= ACCEPT at that same edge.
- The number of change pulses equals the credit on entry to CHANGE.

Any coin while in VEND or CHANGE:
- The coin is not credited; coin_return <= 1 at that edge.
- cancel is ignored in VEND and CHANGE.

Latency:
- From the coin edge that reaches the price to dispense=1 is one cycle.
- The first change pulse follows dispense by one cycle.

Credit never underflows. The CHANGE exit rule guarantees credit reaches exactly 0.

Test Plan:
- Reset then idle: clrbar=0 for 2 cycles, then 1 -> credit=0, dispense=change=coin_return=busy=0, state ACCEPT.
- Exact price: dime, dime on separate edges -> credit 2 then 4, dispense=1 for one cycle, credit=0, no change pulses, busy high for exactly 1 cycle.
- Overpay with change: nickel, dime, then quarter -> credit 1, 3, 8; dispense=1 (credit=4); then 4 consecutive change pulses with credit 3,2,1,0; busy drops with the last pulse.
- Rejections: nickel+dime high at the same edge -> coin_return=1, credit unchanged. Quarter while busy in CHANGE -> coin_return=1, change sequence unaltered.
- Cancel paths: dime then cancel -> 2 change pulses, no dispense. Cancel with credit=0 -> no response. Cancel plus nickel at the same edge with credit 3 -> coin_return=1 and 3 change pulses.
- Reset mid-operation: assert clrbar=0 during the second of 4 change pulses -> next edge credit=0, change=0, busy=0. A subsequent nickel is credited normally (credit=1).

Source files
------------

// File: rtl/vend_ctrl.sv
// ---------------------------------------------------------------------------
// vend_ctrl : coin-accumulating vending controller (credit, vend, change)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vend_ctrl #(
  parameter int PRICE_N      = 4,
  parameter int CREDIT_W     = 4,
  parameter int MAX_CREDIT_N = 15
) (
  input  logic                clk,
  input  logic                clrbar,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  output logic                dispense,
  output logic                change,
  output logic                coin_return,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] C_PRICE     = CREDIT_W'(PRICE_N);
  localparam logic [CREDIT_W:0]   C_PRICE_EXT = (CREDIT_W+1)'(PRICE_N);
  localparam logic [CREDIT_W:0]   C_MAX_EXT   = (CREDIT_W+1)'(MAX_CREDIT_N);
  localparam logic [CREDIT_W-1:0] C_ONE       = CREDIT_W'(1);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_q, dispense_d;
  logic                change_q, change_d;
  logic                coin_return_q, coin_return_d;
  logic                busy_q, busy_d;

  logic [1:0]          w_ncoins;
  logic                w_any_coin;
  logic [CREDIT_W:0]   w_value;
  logic [CREDIT_W:0]   w_sum;

  assign w_ncoins   = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};
  assign w_any_coin = (w_ncoins != 2'd0);

  always_comb begin
    w_value = '0;
    if (nickel)       w_value = (CREDIT_W+1)'(1);
    else if (dime)    w_value = (CREDIT_W+1)'(2);
    else if (quarter) w_value = (CREDIT_W+1)'(5);
  end

  // One bit wider than the credit register so an overflowing coin is seen, not wrapped.
  assign w_sum = {1'b0, credit_q} + w_value;

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    dispense_d    = 1'b0;
    change_d      = 1'b0;
    coin_return_d = 1'b0;

    case (state_q)
      ACCEPT: begin
        if (cancel && (credit_q != '0)) begin
          state_d       = CHANGE;
          coin_return_d = w_any_coin;
        end else if (w_ncoins > 2'd1) begin
          coin_return_d = 1'b1;
        end else if (w_ncoins == 2'd1) begin
          if (w_sum > C_MAX_EXT) begin
            coin_return_d = 1'b1;
          end else begin
            credit_d = w_sum[CREDIT_W-1:0];
            if (w_sum >= C_PRICE_EXT) state_d = VEND;
          end
        end
      end

      VEND: begin
        dispense_d    = 1'b1;
        credit_d      = credit_q - C_PRICE;
        state_d       = (credit_q != C_PRICE) ? CHANGE : ACCEPT;
        coin_return_d = w_any_coin;
      end

      CHANGE: begin
        coin_return_d = w_any_coin;
        // Exit on the last nickel so credit lands exactly on zero.
        if (credit_q == '0) begin
          state_d = ACCEPT;
        end else begin
          change_d = 1'b1;
          credit_d = credit_q - C_ONE;
          if (credit_q == C_ONE) state_d = ACCEPT;
        end
      end

      default: begin
        state_d  = ACCEPT;
        credit_d = '0;
      end
    endcase

    busy_d = (state_d != ACCEPT);
  end

  always_ff @(posedge clk) begin
    if (!clrbar) begin
      state_q       <= ACCEPT;
      credit_q      <= '0;
      dispense_q    <= 1'b0;
      change_q      <= 1'b0;
      coin_return_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      dispense_q    <= dispense_d;
      change_q      <= change_d;
      coin_return_q <= coin_return_d;
      busy_q        <= busy_d;
    end
  end

  assign dispense    = dispense_q;
  assign change      = change_q;
  assign coin_return = coin_return_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vend_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_ctrl : directed self-checking bench for vend_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vend_ctrl;

  logic       clk;
  logic       clrbar;
  logic       nickel, dime, quarter, cancel;
  logic       dispense, change, coin_return, busy;
  logic [3:0] credit;

  int n_tests;
  int n_fail;

  vend_ctrl #(
    .PRICE_N      (4),
    .CREDIT_W     (4),
    .MAX_CREDIT_N (15)
  ) u_dut (
    .clk         (clk),
    .clrbar      (clrbar),
    .nickel      (nickel),
    .dime        (dime),
    .quarter     (quarter),
    .cancel      (cancel),
    .dispense    (dispense),
    .change      (change),
    .coin_return (coin_return),
    .credit      (credit),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got {credit,disp,chg,ret,busy}=%h_%b%b%b%b expected %h_%b%b%b%b",
               tag, obs[7:4], obs[3], obs[2], obs[1], obs[0],
               exp_v[7:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  // Apply inputs for one edge, then release them 1 time unit after the edge.
  task automatic tick(input logic rn, input logic n, input logic d, input logic q, input logic c);
    clrbar  = rn;
    nickel  = n;
    dime    = d;
    quarter = q;
    cancel  = c;
    @(posedge clk);
    #1;
    clrbar  = 1'b1;
    nickel  = 1'b0;
    dime    = 1'b0;
    quarter = 1'b0;
    cancel  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int cr, input logic d, input logic ch,
                            input logic rt, input logic b);
    chk(tag, {credit, dispense, change, coin_return, busy}, {4'(cr), d, ch, rt, b});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clrbar = 1'b0; nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;

    // reset and idle
    tick(0, 0, 0, 0, 0); expect_out("rst1",  0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0); expect_out("rst2",  0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0); expect_out("idle",  0, 0, 0, 0, 0);

    // exact price: dime, dime
    tick(1, 0, 1, 0, 0); expect_out("ex_d1",   2, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0); expect_out("ex_d2",   4, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0); expect_out("ex_vend", 0, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0); expect_out("ex_post", 0, 0, 0, 0, 0);

    // overpay: nickel, dime, quarter -> vend then 4 change pulses
    tick(1, 1, 0, 0, 0); expect_out("op_n",    1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0); expect_out("op_d",    3, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0); expect_out("op_q",    8, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0); expect_out("op_vend", 4, 1, 0, 0, 1);
    tick(1, 0, 0, 0, 0); expect_out("op_c1",   3, 0, 1, 0, 1);
    tick(1, 0, 0, 0, 0); expect_out("op_c2",   2, 0, 1, 0, 1);
    tick(1, 0, 0, 0, 0); expect_out("op_c3",   1, 0, 1, 0, 1);
    tick(1, 0, 0, 0, 0); expect_out("op_c4",   0, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0); expect_out("op_post", 0, 0, 0, 0, 0);

    // rejections: two coins together, coin during VEND and CHANGE
    tick(1, 1, 1, 0, 0); expect_out("rj_multi", 0, 0, 0, 1, 0);
    tick(1, 1, 0, 0, 0); expect_out("rj_n",     1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0); expect_out("rj_q",     6, 0, 0, 0, 1);
    tick(1, 0, 1, 0, 1); expect_out("rj_vend",  2, 1, 0, 1, 1);
    tick(1, 0, 0, 1, 1); expect_out("rj_chg1",  1, 0, 1, 1, 1);
    tick(1, 0, 0, 0, 0); expect_out("rj_chg2",  0, 0, 1, 0, 0);

    // cancel with credit 2
    tick(1, 0, 1, 0, 0); expect_out("cn_d",   2, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1); expect_out("cn_cxl", 2, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0); expect_out("cn_c1",  1, 0, 1, 0, 1);
    tick(1, 0, 0, 0, 0); expect_out("cn_c2",  0, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0); expect_out("cn_post",0, 0, 0, 0, 0);

    // cancel with zero credit is ignored; a coin alongside is accepted
    tick(1, 0, 0, 0, 1); expect_out("cz_none", 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 1); expect_out("cz_coin", 1, 0, 0, 0, 0);

    // cancel + nickel with credit 3
    tick(1, 0, 1, 0, 0); expect_out("cc_d",   3, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 1); expect_out("cc_cxl", 3, 0, 0, 1, 1);
    tick(1, 0, 0, 0, 0); expect_out("cc_c1",  2, 0, 1, 0, 1);
    tick(1, 0, 0, 0, 0); expect_out("cc_c2",  1, 0, 1, 0, 1);
    tick(1, 0, 0, 0, 0); expect_out("cc_c3",  0, 0, 1, 0, 0);

    // reset in the middle of a change train
    tick(1, 1, 0, 0, 0); expect_out("rm_n",    1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0); expect_out("rm_d",    3, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0); expect_out("rm_q",    8, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0); expect_out("rm_vend", 4, 1, 0, 0, 1);
    tick(1, 0, 0, 0, 0); expect_out("rm_c1",   3, 0, 1, 0, 1);
    tick(0, 0, 0, 0, 0); expect_out("rm_rst",  0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0); expect_out("rm_n2",   1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
